// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU time-share scheduler and future
// shared-resource blocks.
package alu_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } sched_state_e;

    localparam int FLAG_C     = 0;
    localparam int FLAG_Z     = 1;
    localparam int FLAG_V     = 2;
    localparam int OP_COUNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above
// ptr, wrapping from NUM_REQ-1 back to 0.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % NUM_REQ);
            if (en && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler time-sharing one external 4-bit ALU between NUM_REQ
// requesters; one operation in flight, response tagged with requester index.
module alu_share_sched
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ALU_WAIT = 1,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [4*NUM_REQ-1:0]  req_a,
    input  logic [4*NUM_REQ-1:0]  req_b,
    input  logic [2*NUM_REQ-1:0]  req_op,
    output logic [3:0]            alu_a,
    output logic [3:0]            alu_b,
    output logic [1:0]            alu_op,
    input  logic [3:0]            alu_result,
    input  logic                  alu_carry,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [3:0]            rsp_result,
    output logic [2:0]            rsp_flags,
    output logic                  busy,
    output logic [OP_COUNT_W-1:0] op_count,
    output sched_state_e          dbg_state
);

    // Handshakes: a request transfers on the edge where req_valid[i] and
    // req_ready[i] are both high; a response transfers on rsp_valid & rsp_ready.
    // Valid never waits on ready; ready may follow valid combinationally.

    sched_state_e          state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [OP_COUNT_W-1:0] op_count_q, op_count_d;
    logic [ID_W-1:0]       id_q, id_d;
    logic [3:0]            alu_a_q, alu_a_d;
    logic [3:0]            alu_b_q, alu_b_d;
    logic [1:0]            alu_op_q, alu_op_d;
    logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
    logic [3:0]            rsp_result_q, rsp_result_d;
    logic [2:0]            rsp_flags_q, rsp_flags_d;

    logic [NUM_REQ-1:0]    grant;
    logic [ID_W-1:0]       grant_id;
    logic [3:0]            a_arr  [NUM_REQ];
    logic [3:0]            b_arr  [NUM_REQ];
    logic [1:0]            op_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i]  = req_a[4*i +: 4];
        assign b_arr[i]  = req_b[4*i +: 4];
        assign op_arr[i] = req_op[2*i +: 2];
    end

    // rst gates the arbiter so req_ready reads 0 for the whole reset pulse.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_valid),
        .ptr      (rr_ptr_q),
        .en       ((state_q == IDLE) && !rst),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        wait_cnt_d   = wait_cnt_q;
        op_count_d   = op_count_q;
        id_d         = id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_op_d     = alu_op_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    alu_a_d    = a_arr[grant_id];
                    alu_b_d    = b_arr[grant_id];
                    alu_op_d   = op_arr[grant_id];
                    id_d       = grant_id;
                    wait_cnt_d = 4'(ALU_WAIT - 1);
                    rr_ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
                    state_d    = EXEC;
                end
            end
            EXEC: begin
                if (wait_cnt_q == 4'd0) begin
                    rsp_id_d             = id_q;
                    rsp_result_d         = alu_result;
                    rsp_flags_d[FLAG_C]  = alu_carry;
                    rsp_flags_d[FLAG_Z]  = alu_zero;
                    rsp_flags_d[FLAG_V]  = alu_overflow;
                    alu_a_d              = '0;
                    alu_b_d              = '0;
                    alu_op_d             = '0;
                    state_d              = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    op_count_d = (op_count_q == '1) ? op_count_q : op_count_q + 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            wait_cnt_q   <= '0;
            op_count_q   <= '0;
            id_q         <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            op_count_q   <= op_count_d;
            id_q         <= id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_op_q     <= alu_op_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign req_ready  = grant;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_op     = alu_op_q;
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;
    assign busy       = (state_q != IDLE);
    assign op_count   = op_count_q;
    assign dbg_state  = state_q;

endmodule
